fetch_sequencer: RTL



---
 rtl/fetch_sequencer.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch front end. Issues sequential word fetches
// to the memory/MMU port, tracks up to MAX_OUTSTANDING in-flight requests,
// and forwards in-order responses (with PC and MMU status) to the loop buffer.
//
// State | meaning
// ------+------------------------------------------------------------
// RUN   | issuing requests whenever credit and the loop buffer allow
// STOP  | loop buffer asked to stop; resume when both stop/lock drop
// FAULT | page fault seen (or misaligned redirect); wait for refresh
//
// Optional build macro MIST1032ISA_FETCH_ALIGN_CHECK_EN: a refresh target with
// nonzero low bits produces a single faulting entry instead of a fetch.
// Without it the low two bits of the target are simply cleared.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iFREE_REFRESH,
  input  logic [31:0] iFREE_BRANCH_PC,
  input  logic        iSYSREG_PAGING_ENA,
  input  logic        iSYSREG_KERNEL,
  output logic        oMEM_REQ,
  output logic [31:0] oMEM_ADDR,
  input  logic        iMEM_LOCK,
  input  logic        iMEM_VALID,
  input  logic [31:0] iMEM_DATA,
  input  logic        iMEM_PAGEFAULT,
  input  logic [13:0] iMEM_MMU_FLAGS,
  output logic        oNEXT_INST_VALID,
  output logic        oNEXT_PAGEFAULT,
  output logic        oNEXT_PAGING_ENA,
  output logic        oNEXT_KERNEL_ACCESS,
  output logic        oNEXT_BRANCH_PREDICT,
  output logic [13:0] oNEXT_MMU_FLAGS,
  output logic [31:0] oNEXT_INST,
  output logic [31:0] oNEXT_PC,
  input  logic        iNEXT_FETCH_STOP,
  input  logic        iNEXT_LOCK
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STOP       = 2'd1,
    FAULT_HOLD = 2'd2
  } state_t;

  state_t             state;
  state_t             stateNext;
  logic [31:0]        pcReg;
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   discard;
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdPtr;
  logic [31:0]        qPc     [MAX_OUTSTANDING];
  logic               qPaging [MAX_OUTSTANDING];
  logic               qKernel [MAX_OUTSTANDING];

  logic               memReq;
  logic               accept;
  logic               respKeep;
  logic               respDrop;
  logic               alignFault;
  logic [31:0]        refreshTarget;

  // Ring-buffer pointer advance; depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept        = memReq && !iMEM_LOCK;
  assign respKeep      = iMEM_VALID && (discard == '0);
  assign respDrop      = iMEM_VALID && (discard != '0);
  assign refreshTarget = iFREE_BRANCH_PC & 32'hFFFF_FFFC;

`ifdef MIST1032ISA_FETCH_ALIGN_CHECK_EN
  assign alignFault = iFREE_REFRESH && (iFREE_BRANCH_PC[1:0] != 2'b00);
`else
  assign alignFault = 1'b0;
`endif

  assign oNEXT_BRANCH_PREDICT = 1'b0;

  // FSM state register.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  // FSM next state: refresh beats a fault, a fault beats stop/resume.
  always_comb begin
    stateNext = state;
    if (iFREE_REFRESH) begin
      stateNext = alignFault ? FAULT_HOLD : RUN;
    end else if (respKeep && iMEM_PAGEFAULT) begin
      stateNext = FAULT_HOLD;
    end else begin
      case (state)
        RUN: begin
          if (iNEXT_FETCH_STOP || iNEXT_LOCK) begin
            stateNext = STOP;
          end
        end
        STOP: begin
          if (!iNEXT_FETCH_STOP && !iNEXT_LOCK) begin
            stateNext = RUN;
          end
        end
        FAULT_HOLD: begin
          stateNext = FAULT_HOLD;
        end
        default: begin
          stateNext = RUN;
        end
      endcase
    end
  end

  // FSM outputs: request is combinational so stop/refresh suppress it at once.
  always_comb begin
    memReq = inRESET && (state == RUN) &&
             (outstanding < CNT_W'(MAX_OUTSTANDING)) &&
             !iNEXT_FETCH_STOP && !iNEXT_LOCK && !iFREE_REFRESH;
    oMEM_REQ  = memReq;
    oMEM_ADDR = pcReg;
  end

  // Fetch PC: redirect on refresh, otherwise advance on each accepted request.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      pcReg <= RESET_PC;
    end else if (iFREE_REFRESH) begin
      pcReg <= refreshTarget;
    end else if (accept) begin
      pcReg <= pcReg + 32'd4;
    end
  end

  // In-flight accounting. Every response retires one outstanding request;
  // on refresh everything still in flight becomes a response to drop.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(accept) - CNT_W'(iMEM_VALID);
      if (iFREE_REFRESH) begin
        discard <= outstanding + CNT_W'(accept) - CNT_W'(iMEM_VALID);
      end else if (respDrop) begin
        discard <= discard - 1'b1;
      end
    end
  end

  // PC queue: holds {pc, paging, kernel} for live requests only.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wrPtr <= '0;
      rdPtr <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        qPc[i]     <= '0;
        qPaging[i] <= 1'b0;
        qKernel[i] <= 1'b0;
      end
    end else if (iFREE_REFRESH) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (accept) begin
        qPc[wrPtr]     <= pcReg;
        qPaging[wrPtr] <= iSYSREG_PAGING_ENA;
        qKernel[wrPtr] <= iSYSREG_KERNEL;
        wrPtr          <= ptrInc(wrPtr);
      end
      if (respKeep) begin
        rdPtr <= ptrInc(rdPtr);
      end
    end
  end

  // Loop-buffer entry register: one-cycle pulse per kept response.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      oNEXT_INST_VALID    <= 1'b0;
      oNEXT_PAGEFAULT     <= 1'b0;
      oNEXT_PAGING_ENA    <= 1'b0;
      oNEXT_KERNEL_ACCESS <= 1'b0;
      oNEXT_MMU_FLAGS     <= '0;
      oNEXT_INST          <= '0;
      oNEXT_PC            <= '0;
    end else begin
      oNEXT_INST_VALID <= 1'b0;
      if (iFREE_REFRESH) begin
        if (alignFault) begin
          // Misaligned target reported as a faulting entry at the raw address.
          oNEXT_INST_VALID    <= 1'b1;
          oNEXT_PAGEFAULT     <= 1'b1;
          oNEXT_PAGING_ENA    <= iSYSREG_PAGING_ENA;
          oNEXT_KERNEL_ACCESS <= iSYSREG_KERNEL;
          oNEXT_MMU_FLAGS     <= '0;
          oNEXT_INST          <= '0;
          oNEXT_PC            <= iFREE_BRANCH_PC;
        end
      end else if (respKeep) begin
        oNEXT_INST_VALID    <= 1'b1;
        oNEXT_PAGEFAULT     <= iMEM_PAGEFAULT;
        oNEXT_PAGING_ENA    <= qPaging[rdPtr];
        oNEXT_KERNEL_ACCESS <= qKernel[rdPtr];
        oNEXT_MMU_FLAGS     <= iMEM_MMU_FLAGS;
        oNEXT_INST          <= iMEM_DATA;
        oNEXT_PC            <= qPc[rdPtr];
      end
    end
  end

endmodule
